// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared
// combinational ALU. One operation is in flight at a time:
// IDLE (grant) -> EXEC (drive ALU, capture result) -> RESP (hold until taken).
//
// Ports
//   clk, rst                   clock, async active-high reset
//   reqN_valid/op/a/b          requester N operation (N = 0,1)
//   reqN_ready                 requester N accepted this cycle (combinational)
//   alu_a/alu_b/alu_ctrl      operands/control to the shared ALU (registered)
//   alu_result/alu_flags       ALU outputs, flags = {zero, neg, carry, ovf}
//   resp_valid/resp_ready      response handshake
//   resp_id                    owner of the response
//   resp_result/resp_flags     captured ALU outputs
//   resp_err                   op code was illegal
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [2:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [2:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [3:0]            alu_flags,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic [3:0]            resp_flags,
  output logic                  resp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  id;
  } req_t;

  state_t state, state_nxt;
  logic   prio;       // requester favoured on a tie
  logic   grant_id;
  logic   accept;
  logic   op_bad;
  req_t   lat, grant_req;

  // Tie goes to the pointer; otherwise whoever is asking.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = prio;
    else if (req1_valid)          grant_id = 1'b1;
  end

  // rst gates the readies so every output is 0 while reset is held.
  assign accept     = (state == IDLE) && (req0_valid || req1_valid) && !rst;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  assign grant_req = grant_id ? req_t'{req1_op, req1_a, req1_b, 1'b1}
                              : req_t'{req0_op, req0_a, req0_b, 1'b0};

  always_comb begin
    case (lat.op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: op_bad = 1'b0;
      default:                                op_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      lat         <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
      resp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) lat <= grant_req;
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_flags  <= alu_flags;
        resp_err    <= op_bad;
      end
      // Pointer moves only once the response is consumed.
      if (state == RESP && resp_ready) prio <= ~lat.id;
    end
  end

  // Latched operands stay on the ALU bus between operations.
  assign alu_a      = lat.a;
  assign alu_b      = lat.b;
  assign alu_ctrl   = lat.op;
  assign resp_id    = lat.id;
  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_ctrl;
  logic [3:0]   alu_flags;
  logic         resp_valid, resp_ready, resp_id, resp_err;
  logic [W-1:0] resp_result;
  logic [3:0]   resp_flags;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err)
  );

  // Shared ALU: add, sub, and, or, xor; anything else gives 0.
  logic [W:0] sum;
  logic       c_f, v_f;
  always_comb begin
    sum        = '0;
    c_f        = 1'b0;
    v_f        = 1'b0;
    alu_result = '0;
    case (alu_ctrl)
      3'b000: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[W-1:0];
        c_f = sum[W];
        v_f = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      3'b001: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
        alu_result = sum[W-1:0];
        c_f = sum[W];
        v_f = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
    alu_flags = {alu_result == '0, alu_result[W-1], c_f, v_f};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with the FSM idle; returns one
  // falling edge after the grant edge with valid dropped.
  task automatic issue(input bit n, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    if (n) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    chk("grant_r0", req0_ready, !n);
    chk("grant_r1", req1_ready, n);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic id, input logic [W-1:0] res,
                           input logic [3:0] fl, input logic err, input int hold);
    int cnt = 0;
    while (!resp_valid && cnt < 10) begin @(negedge clk); cnt++; end
    chk({tag, "_valid"},   resp_valid, 1'b1);
    chk({tag, "_latency"}, cnt, 1);
    chk({tag, "_id"},      resp_id, id);
    chk({tag, "_result"},  resp_result, res);
    chk({tag, "_flags"},   resp_flags, fl);
    chk({tag, "_err"},     resp_err, err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"},  resp_valid, 1'b1);
      chk({tag, "_hold_result"}, resp_result, res);
      chk({tag, "_hold_flags"},  resp_flags, fl);
      chk({tag, "_hold_ready"},  {req0_ready, req1_ready}, 2'b00);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_done"}, resp_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    #1;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_alu", {alu_a, alu_ctrl}, '0);
    chk("rst_resp", {resp_id, resp_err, resp_flags, resp_result}, '0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // add 5+7 from requester 0; operands visible on the ALU during EXEC
    issue(1'b0, 3'b000, 32'd5, 32'd7);
    chk("exec_alu_a", alu_a, 32'd5);
    chk("exec_alu_b", alu_b, 32'd7);
    chk("exec_ctrl",  alu_ctrl, 3'b000);
    chk("exec_ready", {req0_ready, req1_ready}, 2'b00);
    wait_resp("add", 1'b0, 32'd12, 4'b0000, 1'b0, 0);
    chk("idle_alu_hold", alu_a, 32'd5);

    // sub 3-5 from requester 1: negative, no carry, no overflow
    issue(1'b1, 3'b001, 32'd3, 32'd5);
    wait_resp("sub", 1'b1, 32'hFFFF_FFFE, 4'b0100, 1'b0, 0);

    // both held valid: grants alternate 0,1,0,1
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'hF0; req0_b = 32'h3C;
    req1_valid = 1'b1; req1_op = 3'b011; req1_a = 32'hF0; req1_b = 32'h0F;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int cnt = 0;
      #1;
      while (!(req0_ready || req1_ready) && cnt < 10) begin @(negedge clk); #1; cnt++; end
      chk("b2b_grant", {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
      @(negedge clk); @(negedge clk);
      chk("b2b_valid", resp_valid, 1'b1);
      chk("b2b_id", resp_id, k % 2);
      chk("b2b_result", resp_result, (k % 2) ? 32'hFF : 32'h30);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);

    // xor with response held back 5 cycles; req1 asks meanwhile then withdraws
    issue(1'b0, 3'b101, 32'd6, 32'd3);
    req1_valid = 1'b1; req1_op = 3'b000;
    wait_resp("hold", 1'b0, 32'd5, 4'b0000, 1'b0, 5);
    #1;
    chk("hold_back_idle", req1_ready, 1'b1);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("withdrawn_no_resp", resp_valid, 1'b0);

    // illegal op passes the ALU output through with err set
    issue(1'b0, 3'b111, 32'd9, 32'd9);
    wait_resp("illegal", 1'b0, 32'd0, 4'b1000, 1'b1, 0);

    // reset mid-EXEC (pointer currently favours requester 1)
    issue(1'b0, 3'b000, 32'd1, 32'd2);
    req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd2;
    rst = 1'b1;
    #1;
    chk("midrst_alu", {alu_a, alu_b, alu_ctrl}, '0);
    chk("midrst_resp", {resp_valid, resp_id, resp_err, resp_flags, resp_result}, '0);
    chk("midrst_ready", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    chk("midrst_no_resp", resp_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("postrst_grant", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp("postrst", 1'b0, 32'd3, 4'b0000, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the operand and result width.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, meaning reset: asynchronous, active-high.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each, meaning requester N has an operation pending.
REQ-005 SHALL have ports req0_op and req1_op, input, 3 bits each, meaning ALU control code.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, DATA_WIDTH each, meaning operands.
REQ-007 SHALL have ports req0_ready and req1_ready, output, 1 bit each, meaning the request is accepted this cycle.
REQ-008 SHALL have port alu_a, output, DATA_WIDTH, and port alu_b, output, DATA_WIDTH, meaning operands driven to the shared ALU.
REQ-009 SHALL have port alu_ctrl, output, 3 bits, meaning control code driven to the shared ALU.
REQ-010 SHALL have port alu_result, input, DATA_WIDTH, meaning combinational result from the shared ALU.
REQ-011 SHALL have port alu_flags, input, 4 bits, meaning {zero, negative, carry, overflow} from the ALU.
REQ-012 SHALL have port resp_valid, output, 1 bit, and port resp_ready, input, 1 bit, meaning the response handshake.
REQ-013 SHALL have port resp_id, output, 1 bit, meaning the index of the requester that owns the response.
REQ-014 SHALL have port resp_result, output, DATA_WIDTH, and port resp_flags, output, 4 bits, meaning the registered ALU outputs.
REQ-015 SHALL have port resp_err, output, 1 bit, meaning the op code was illegal.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-017 IDLE: if any reqN_valid, SHALL grant exactly one requester, assert only its reqN_ready combinationally, latch op, a, b and id, and go to EXEC.
REQ-018 Arbitration SHALL be round-robin: when both are valid, the requester not served last wins; the priority pointer resets to favour requester 0.
REQ-019 reqN_ready SHALL be 0 in EXEC and RESP; no request is accepted outside IDLE.
REQ-020 EXEC: alu_a, alu_b and alu_ctrl SHALL equal the latched values; at the cycle end, SHALL register alu_result into resp_result and alu_flags into resp_flags, then go to RESP.
REQ-021 alu_a, alu_b and alu_ctrl SHALL hold the last latched values in all states; they are not forced to zero between operations.
REQ-022 RESP: resp_valid SHALL be 1; resp_id, resp_result, resp_flags and resp_err SHALL be stable until resp_ready is 1, then the FSM SHALL go to IDLE and the pointer SHALL update.
REQ-023 Latency: a request accepted at edge T SHALL present resp_valid at T+2 with a 1-cycle EXEC; minimum issue interval is 3 cycles.
REQ-024 Legal op codes SHALL be 000, 001, 010, 011 and 101; any other op SHALL still be issued, with resp_err=1 and result and flags passed through unchanged.
REQ-025 A requester that drops valid before being granted SHALL receive no grant and no response.
REQ-026 resp_ready asserted while not in RESP SHALL be ignored.
REQ-027 Back-to-back: with both requesters held valid, grants SHALL alternate 0,1,0,1.

Reset
REQ-028 When rst is asserted, in any state, the block SHALL immediately enter IDLE with the pointer set to favour requester 0.
REQ-029 When rst is asserted, all outputs SHALL immediately go to 0, and the in-flight transaction SHALL be dropped with no response.
REQ-030 The first grant SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-031 req0 op=000, a=5, b=7, with the ALU model connected -> resp_valid two edges after the grant, resp_id=0, result=12, flags=0000.
REQ-032 req1 op=001, a=3, b=5 -> result=0xFFFFFFFE, flags N=1, C=0, V=0, resp_err=0.
REQ-033 Both requesters valid continuously for 4 transactions -> grants 0,1,0,1; responses arrive in the same order.
REQ-034 resp_ready held 0 for 5 cycles in RESP -> outputs stable, both readies 0, no new grant; on the cycle after resp_ready=1, the FSM is in IDLE.
REQ-035 req0 op=111 -> resp_err=1, and the result passes through from the ALU (0 from the model, flags Z=1).
REQ-036 rst pulse during EXEC -> all outputs 0 immediately, no resp_valid; the next request is granted to requester 0.
